// File: rtl/axil_regmap_slave_if.sv
// AXI-Lite bundle between the firewall master port and its downstream targets.
// N is the byte-lane count (data is 8*N bits); A is the address width.
interface if_axil #(
  parameter int N = 4,
  parameter int A = 32
) ();
  logic [A-1:0]   awaddr;
  logic           awvalid;
  logic           awready;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wvalid;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [A-1:0]   araddr;
  logic           arvalid;
  logic           arready;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_regmap_slave.sv
// AXI-Lite register bank with OKAY/SLVERR/DECERR decode and per-channel stall control.
// Define AXIL_REGMAP_ID_EN to add a read-only ID register just above the R/W bank.
module axil_regmap_slave #(
  parameter int                  G_ADDR_W = 32,
  parameter int                  G_DATA_W = 32,
  parameter logic [G_ADDR_W-1:0] G_BASE   = 'h100,
  parameter int                  G_REG_N  = 4,
  parameter logic [31:0]         G_ID     = 32'hA5A5_0001
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_err,
  input  logic [4:0] i_hsk_ena,
  if_axil.slave      s_axil,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int         STRB_W      = G_DATA_W / 8;

  localparam logic [G_ADDR_W-1:0] REG_SPAN = G_ADDR_W'(4 * G_REG_N);
  localparam logic [G_ADDR_W-1:0] ID_ADDR  = G_BASE + REG_SPAN;

`ifdef AXIL_REGMAP_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [G_DATA_W-1:0] regs [G_REG_N];

  function automatic logic in_regs(input logic [G_ADDR_W-1:0] addr);
    return (addr >= G_BASE) && ((addr - G_BASE) < REG_SPAN);
  endfunction

  function automatic logic [3:0] reg_idx(input logic [G_ADDR_W-1:0] addr);
    return 4'((addr - G_BASE) >> 2);
  endfunction

  // Error injection and misalignment outrank the address-range check.
  function automatic logic [1:0] decode(input logic [G_ADDR_W-1:0] addr,
                                        input logic err, input logic wr);
    if (err || addr[1:0] != 2'b00) return RESP_SLVERR;
    if (in_regs(addr)) return RESP_OKAY;
    if (ID_EN && addr == ID_ADDR) return wr ? RESP_SLVERR : RESP_OKAY;
    return RESP_DECERR;
  endfunction

  // Handshakes: a transfer happens on an edge where valid && ready are both 1.
  // A valid, once raised, is held until its transfer; i_hsk_ena only masks the
  // visible ready/valid and never discards a pending beat.

  // ---------------- write channel ----------------
  logic                aw_rdy, w_rdy, aw_got, w_got;
  logic [G_ADDR_W-1:0] aw_addr_q;
  logic [G_DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic [1:0]          bresp_q;
  logic                aw_hs, w_hs, b_hs, w_fire;
  logic [G_ADDR_W-1:0] w_addr_eff;
  logic [G_DATA_W-1:0] w_data_eff;
  logic [STRB_W-1:0]   w_strb_eff;
  logic [1:0]          w_resp;
  logic [3:0]          w_idx;

  assign s_axil.awready = aw_rdy & i_hsk_ena[0];
  assign s_axil.wready  = w_rdy & i_hsk_ena[1];
  assign s_axil.bvalid  = (w_state == W_RESP) & i_hsk_ena[2];
  assign s_axil.bresp   = bresp_q;

  assign aw_hs = s_axil.awvalid & s_axil.awready;
  assign w_hs  = s_axil.wvalid & s_axil.wready;
  assign b_hs  = s_axil.bvalid & s_axil.bready;

  // The later of the two beats may still be on the bus, so merge it with the latch.
  assign w_fire     = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign w_addr_eff = aw_got ? aw_addr_q : s_axil.awaddr;
  assign w_data_eff = w_got ? w_data_q : s_axil.wdata;
  assign w_strb_eff = w_got ? w_strb_q : s_axil.wstrb;
  assign w_resp     = decode(w_addr_eff, i_err, 1'b1);
  assign w_idx      = reg_idx(w_addr_eff);

  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE: if (w_fire) w_state_n = W_RESP;
      W_RESP: if (b_hs) w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      w_state   <= W_IDLE;
      aw_rdy    <= 1'b0;
      w_rdy     <= 1'b0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state <= w_state_n;
      // Readies are registered, so they reopen one cycle after the response completes.
      aw_rdy  <= (w_state == W_IDLE) && (w_state_n == W_IDLE) && !(aw_got || aw_hs);
      w_rdy   <= (w_state == W_IDLE) && (w_state_n == W_IDLE) && !(w_got || w_hs);
      if (w_fire) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        bresp_q <= w_resp;
      end else begin
        if (aw_hs) begin
          aw_got    <= 1'b1;
          aw_addr_q <= s_axil.awaddr;
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          w_data_q <= s_axil.wdata;
          w_strb_q <= s_axil.wstrb;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < G_REG_N; i++) regs[i] <= '0;
    end else if (w_fire && w_resp == RESP_OKAY) begin
      for (int i = 0; i < G_REG_N; i++) begin
        if (w_idx == 4'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_eff[b]) regs[i][8*b +: 8] <= w_data_eff[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------- read channel ----------------
  logic                rdy_en;
  logic                ar_hs, r_hs;
  logic [1:0]          r_resp, rresp_q;
  logic [G_DATA_W-1:0] r_sel, r_data_n, rdata_q;
  logic [3:0]          r_idx;

  assign s_axil.arready = rdy_en & (r_state == R_IDLE) & i_hsk_ena[3];
  assign s_axil.rvalid  = (r_state == R_DATA) & i_hsk_ena[4];
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

  assign ar_hs = s_axil.arvalid & s_axil.arready;
  assign r_hs  = s_axil.rvalid & s_axil.rready;
  assign r_idx = reg_idx(s_axil.araddr);

  // regs is sampled before a same-edge write lands, so a colliding read sees the old value.
  always_comb begin
    r_sel = '0;
    for (int i = 0; i < G_REG_N; i++) begin
      if (r_idx == 4'(i)) r_sel = regs[i];
    end
    r_resp   = decode(s_axil.araddr, i_err, 1'b0);
    r_data_n = '0;
    if (r_resp == RESP_OKAY) r_data_n = in_regs(s_axil.araddr) ? r_sel : G_DATA_W'(G_ID);
  end

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_n = R_DATA;
      R_DATA: if (r_hs) r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= R_IDLE;
      rdy_en  <= 1'b0;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      r_state <= r_state_n;
      rdy_en  <= 1'b1;
      if (ar_hs) begin
        rresp_q <= r_resp;
        rdata_q <= r_data_n;
      end
    end
  end

  assign dbg_state = {r_state == R_DATA, w_state == W_RESP};

endmodule

// File: tb/tb_axil_regmap_slave.sv
// Directed bench for axil_regmap_slave: register access, decode errors, stalls and reset.
// Honours AXIL_REGMAP_ID_EN for the ID-register expectations.
module tb_axil_regmap_slave;

  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  DECERR = 2'b11;
  localparam logic [31:0] BASE   = 32'h100;
  localparam int          REG_N  = 4;
  localparam logic [31:0] ID     = 32'hA5A5_0001;
`ifdef AXIL_REGMAP_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       err;
  logic [4:0] hsk;
  logic [1:0] dbg;

  if_axil #(.N(4), .A(32)) axil ();

  axil_regmap_slave #(
    .G_ADDR_W(32), .G_DATA_W(32), .G_BASE(BASE), .G_REG_N(REG_N), .G_ID(ID)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_err(err), .i_hsk_ena(hsk),
    .s_axil(axil), .dbg_state(dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [31:0] model [REG_N];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [33:0] obs);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s: observed %0h expected <nothing queued>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic e, input logic wr);
    if (e) return SLVERR;
    if (a[1:0] != 2'b00) return SLVERR;
    if (a >= BASE && a < BASE + 4 * REG_N) return OKAY;
    if (ID_EN && a == BASE + 4 * REG_N) return wr ? SLVERR : OKAY;
    return DECERR;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int i;
    if (a >= BASE && a < BASE + 4 * REG_N) begin
      i = int'((a - BASE) >> 2);
      return model[i];
    end
    return ID;
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int i;
    i = int'((a - BASE) >> 2);
    for (int b = 0; b < 4; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_resp(input string tag, input logic is_rd);
    int   lat;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      seen = is_rd ? (axil.rvalid === 1'b1) : (axil.bvalid === 1'b1);
    end
    check({tag, "_lat"}, 64'(lat), 64'd1);
    if (is_rd) pop_check(tag, {axil.rresp, axil.rdata});
    else       pop_check(tag, {axil.bresp, 32'h0});
    @(posedge clk); #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_block);
    logic [1:0] r;
    logic       aw_done, w_done, aw_hs, w_hs;
    int         cyc, leak;
    r = model_resp(a, err, 1'b1);
    exp_q.push_back({r, 32'h0});
    if (r == OKAY) model_wr(a, d, s);
    if (w_block > 0) hsk[1] = 1'b0;
    axil.awaddr = a;  axil.awvalid = 1'b1;
    axil.wdata  = d;  axil.wstrb   = s;  axil.wvalid = 1'b1;
    axil.bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0; leak = 0;
    while (!(aw_done && w_done) && cyc < w_block + 100) begin
      @(negedge clk);
      aw_hs = axil.awvalid && axil.awready;
      w_hs  = axil.wvalid && axil.wready;
      if (cyc < w_block) leak += int'(axil.wready) + int'(axil.bvalid);
      @(posedge clk); #1;
      if (aw_hs) begin axil.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin axil.wvalid  = 1'b0; w_done  = 1'b1; end
      cyc++;
      if (w_block > 0 && cyc == w_block) hsk[1] = 1'b1;
    end
    hsk[1] = 1'b1;
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    if (w_block > 0) check({tag, "_blocked"}, 64'(leak), 64'd0);
    check({tag, "_accept"}, {aw_done, w_done}, 2'b11);
    wait_resp(tag, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    logic [1:0]  r;
    logic [31:0] d;
    logic        done, hs;
    int          cyc;
    r = model_resp(a, err, 1'b0);
    d = (r == OKAY) ? model_rd(a) : 32'h0;
    exp_q.push_back({r, d});
    axil.araddr = a; axil.arvalid = 1'b1; axil.rready = 1'b1;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      hs = axil.arvalid && axil.arready;
      @(posedge clk); #1;
      if (hs) begin axil.arvalid = 1'b0; done = 1'b1; end
      cyc++;
    end
    axil.arvalid = 1'b0;
    check({tag, "_accept"}, 64'(done), 64'd1);
    wait_resp(tag, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; err = 1'b0; hsk = 5'h1f;
    axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0;
    axil.wvalid = 1'b0; axil.bready = 1'b1; axil.araddr = '0; axil.arvalid = 1'b0;
    axil.rready = 1'b1;
    for (int i = 0; i < REG_N; i++) model[i] = 32'h0;
    #2 rst = 1'b0;
    #20;
    check("rst_readies", {axil.awready, axil.wready, axil.arready}, 3'b000);
    check("rst_valids", {axil.bvalid, axil.rvalid}, 2'b00);
    check("rst_resp_data", {axil.bresp, axil.rresp, axil.rdata}, 36'h0);
    check("rst_fsm", dbg, 2'b00);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("first_edge_readies", {axil.awready, axil.wready, axil.arready}, 3'b111);

    do_write("wr_100", 32'h100, 32'h111, 4'hF, 0);
    do_read("rd_100", 32'h100);

    do_write("wr_107_misaligned", 32'h107, 32'h111, 4'hF, 0);
    do_read("rd_104_untouched", 32'h104);
    do_read("rd_200_decerr", 32'h200);

    err = 1'b1;
    do_write("wr_100_err", 32'h100, 32'h214, 4'hF, 0);
    do_read("rd_108_err", 32'h108);
    err = 1'b0;
    do_read("rd_100_after_err", 32'h100);
    do_write("wr_10c", 32'h10C, 32'h5A5A, 4'hF, 0);

    do_write("wr_104_w_stalled", 32'h104, 32'h321, 4'hF, 20);
    do_read("rd_104_after_stall", 32'h104);

    do_write("wr_108_strb0101", 32'h108, 32'hAABBCCDD, 4'b0101, 0);
    do_read("rd_108_strb0101", 32'h108);

    do_write("wr_10c_strb0", 32'h10C, 32'hFFFF_FFFF, 4'b0000, 0);
    do_read("rd_10c_strb0", 32'h10C);

    do_read("rd_110_id", 32'h110);
    do_write("wr_110_id", 32'h110, 32'h1234, 4'hF, 0);
    do_read("rd_100_before_collide", 32'h100);

    // write and read of reg0 accepted on the same edge
    exp_q.push_back({OKAY, 32'h0});
    exp_q.push_back({OKAY, model[0]});
    model_wr(BASE, 32'hCAFE_F00D, 4'hF);
    axil.awaddr = BASE; axil.awvalid = 1'b1; axil.wdata = 32'hCAFE_F00D;
    axil.wstrb = 4'hF; axil.wvalid = 1'b1; axil.araddr = BASE; axil.arvalid = 1'b1;
    axil.bready = 1'b1; axil.rready = 1'b1;
    @(negedge clk);
    check("collide_ready", {axil.awready, axil.wready, axil.arready}, 3'b111);
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    @(negedge clk);
    check("collide_valid", {axil.bvalid, axil.rvalid}, 2'b11);
    pop_check("collide_b", {axil.bresp, 32'h0});
    pop_check("collide_r_old", {axil.rresp, axil.rdata});
    @(posedge clk); #1;
    do_read("rd_100_after_collide", 32'h100);

    // reset while the write response is stalled by bready=0
    axil.awaddr = 32'h104; axil.awvalid = 1'b1; axil.wdata = 32'h777;
    axil.wstrb = 4'hF; axil.wvalid = 1'b1; axil.bready = 1'b0;
    @(negedge clk);
    check("rst_mid_accept", {axil.awready, axil.wready}, 2'b11);
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    @(negedge clk);
    check("rst_mid_bvalid", {axil.bvalid, dbg[0]}, 2'b11);
    rst = 1'b0;
    #1;
    check("rst_mid_bvalid_drop", {axil.bvalid, dbg}, 3'b000);
    for (int i = 0; i < REG_N; i++) model[i] = 32'h0;
    @(negedge clk); rst = 1'b1;
    axil.bready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < REG_N; i++) do_read("rd_after_reset", BASE + 32'(4 * i));
    do_read("rd_110_after_reset", 32'h110);

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
